fifo_thresh: RTL and testbench
==============================

# fifo_thresh

Parameterised synchronous FIFO that extends the basic push/pop FIFO in four ways:
- any DEPTH, not just powers of two;
- an occupancy count output;
- programmable almost-full and almost-empty flags;
- protected push and pop, plus optional sticky overflow/underflow error flags.

It sits between producer and consumer logic in a single clock domain. The read side is show-ahead (first-word-fall-through).

## Interface

Parameters:
- DEPTH, 6, number of entries; any value ≥ 2.
- DATA_W, 8, width of one entry.
- AFULL_TH, DEPTH-1, almost_full_o asserts when count ≥ AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 1, almost_empty_o asserts when count ≤ AEMPTY_TH; legal range 0..DEPTH-1.
- CNT_W, $clog2(DEPTH+1), derived width of count_o; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- push_i  in  1  push request.
- push_data_i  in  DATA_W  data written on an accepted push.
- pop_i  in  1  pop request.
- pop_data_o  out  DATA_W  head entry; 0 while empty.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- almost_full_o  out  1  count ≥ AFULL_TH.
- almost_empty_o  out  1  count ≤ AEMPTY_TH.
- count_o  out  CNT_W  current occupancy, 0..DEPTH.
- err_clr_i  in  1  clears the sticky error flags.
- overflow_o  out  1  sticky: a push was rejected.
- underflow_o  out  1  sticky: a pop was rejected.

## Operation

Storage:
- DEPTH × DATA_W register array; not reset.
- Binary read and write pointers, range 0..DEPTH-1; each wraps from DEPTH-1 to 0 when incremented.
- Registered occupancy counter, CNT_W bits.

Accept rules:
- acc_pop = pop_i & ~empty_o.
- acc_push = push_i & (~full_o | acc_pop). A push while full is accepted only if a pop is accepted in the same cycle.
- There is no empty bypass. A push and pop together while empty: the push is accepted, the pop is rejected.

Updates on each clock edge:
- acc_push: write push_data_i to mem[wr_ptr], then increment wr_ptr (with wrap).
- acc_pop: increment rd_ptr (with wrap).
- count_next = count + acc_push − acc_pop. Count never leaves 0..DEPTH.

Outputs:
- pop_data_o = mem[rd_ptr] combinationally when ~empty_o, otherwise 0.
- full_o, empty_o, almost_full_o, almost_empty_o and count_o are decoded from the registered count only. They do not depend combinationally on push_i or pop_i.

Error flags (when compiled in):
- overflow_o sets on push_i & full_o & ~acc_pop.
- underflow_o sets on pop_i & empty_o.
- Both flags clear on err_clr_i. If set and clear happen in the same cycle, set wins.
- Rejected operations never modify memory, pointers or count.

## Timing

Reset values, applied immediately and asynchronously when reset_n goes low:
- pointers and count = 0;
- empty_o = 1; almost_empty_o = 1;
- full_o = 0; almost_full_o = 0;
- overflow_o = 0; underflow_o = 0;
- pop_data_o = 0.

Reset is released synchronously: the first state update happens on the first rising edge with reset_n high. Asserting reset mid-operation discards all contents.

Latency:
- An accepted push into an empty FIFO appears on pop_data_o one cycle later.
- Flags and count_o reflect the operations of cycle N in cycle N+1.
- Error flags assert the cycle after the offending request.

Simultaneous push and pop:
- When 0 < count < DEPTH: count is unchanged and data order is preserved.
- When full: pop_data_o shows the old head during the cycle; the written entry lands in the freed slot.

## Configuration

- FIFO_THRESH_ERR_EN defined: overflow/underflow logic is present and behaves as described above.
- FIFO_THRESH_ERR_EN not defined: overflow_o and underflow_o are tied to 0 and err_clr_i is ignored. All ports are still present, and all other behaviour is identical.

## Test plan

All scenarios use DEPTH=6, DATA_W=8, AFULL_TH=5, AEMPTY_TH=1, with FIFO_THRESH_ERR_EN defined.

1. Reset, then push 0x11, 0x22 … 0x66 on consecutive cycles.
   - count_o steps 1 through 6.
   - almost_empty_o drops after the 2nd push.
   - almost_full_o rises after the 5th push; full_o rises after the 6th.
   - Then pop 6 times: pop_data_o reads 0x11 … 0x66 in order, and empty_o = 1 at the end.
2. Push 4, pop 4, then push 0xA0 … 0xA5.
   - Pointers wrap from index 5 to 0.
   - Pops return 0xA0 … 0xA5 in order.
3. When full, push 0x77 and pop together.
   - count_o stays 6; no overflow.
   - The popped value is the old head; 0x77 emerges after five more pops.
4. When full, push 0x88 without pop.
   - overflow_o = 1 next cycle; count_o = 6; contents unchanged.
   - Hold overflow_o for 3 idle cycles, then assert err_clr_i: overflow_o = 0 on the next cycle.
5. When empty, push 0x99 and pop in the same cycle.
   - Next cycle: underflow_o = 1, count_o = 1, pop_data_o = 0x99.
6. At count 3, drop reset_n between clock edges.
   - empty_o = 1, count_o = 0 and pop_data_o = 0 without waiting for a clock edge.
   - After release, push 0x42: pop_data_o = 0x42 one cycle later.

Source files
------------

// File: rtl/fifo_thresh.sv
// Synchronous show-ahead FIFO with any depth, occupancy count, programmable almost flags and
// protected push/pop. Define FIFO_THRESH_ERR_EN to build the sticky overflow/underflow flags.
module fifo_thresh #(
  parameter int DEPTH     = 6,
  parameter int DATA_W    = 8,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [CNT_W-1:0]  count_o,
  input  logic              err_clr_i,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              acc_push;
  logic              acc_pop;

  // Binary pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Status is decoded only from the registered count, never from the requests.
  assign empty_o        = (count == '0);
  assign full_o         = (count == CNT_W'(DEPTH));
  assign almost_full_o  = (count >= CNT_W'(AFULL_TH));
  assign almost_empty_o = (count <= CNT_W'(AEMPTY_TH));
  assign count_o        = count;

  // No empty bypass: a pop while empty is always rejected, even with a push.
  assign acc_pop  = pop_i & ~empty_o;
  assign acc_push = push_i & (~full_o | acc_pop);

  always_comb begin
    count_next = count;
    unique case ({acc_push, acc_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (acc_push) wr_ptr <= ptr_inc(wr_ptr);
      if (acc_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_push) mem[wr_ptr] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem[rd_ptr];

`ifdef FIFO_THRESH_ERR_EN
  logic ovf_set;
  logic udf_set;
  logic ovf_q;
  logic udf_q;

  assign ovf_set = push_i & full_o & ~acc_pop;
  assign udf_set = pop_i & empty_o;

  // Set has priority over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set)        ovf_q <= 1'b1;
      else if (err_clr_i) ovf_q <= 1'b0;
      if (udf_set)        udf_q <= 1'b1;
      else if (err_clr_i) udf_q <= 1'b0;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign overflow_o     = 1'b0;
  assign underflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_thresh.sv
// Directed bench for fifo_thresh: queue-based reference model checked every cycle,
// plus literal expectations along the scenario sequence.
module tb_fifo_thresh;

  localparam int DEPTH  = 6;
  localparam int DATA_W = 8;
  localparam int AF_TH  = 5;
  localparam int AE_TH  = 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef FIFO_THRESH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              push_i = 1'b0;
  logic [DATA_W-1:0] push_data_i = '0;
  logic              pop_i = 1'b0;
  logic [DATA_W-1:0] pop_data_o;
  logic              full_o, empty_o, almost_full_o, almost_empty_o;
  logic [CNT_W-1:0]  count_o;
  logic              err_clr_i = 1'b0;
  logic              overflow_o, underflow_o;

  int checks = 0;
  int errors = 0;

  fifo_thresh #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .push_i(push_i), .push_data_i(push_data_i),
    .pop_i(pop_i), .pop_data_o(pop_data_o),
    .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .count_o(count_o), .err_clr_i(err_clr_i),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  // Reference model: a queue holding the FIFO contents plus two sticky bits.
  logic [DATA_W-1:0] q[$];
  logic              m_ovf = 1'b0;
  logic              m_udf = 1'b0;

  function automatic void model_step();
    int  n;
    bit  ap, ah;
    if (!reset_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      return;
    end
    n  = q.size();
    ap = pop_i && (n > 0);
    ah = push_i && ((n < DEPTH) || ap);
    if (ERR_EN) begin
      if (push_i && n == DEPTH && !ap) m_ovf = 1'b1;
      else if (err_clr_i)              m_ovf = 1'b0;
      if (pop_i && n == 0)             m_udf = 1'b1;
      else if (err_clr_i)              m_udf = 1'b0;
    end
    if (ap) void'(q.pop_front());
    if (ah) q.push_back(push_data_i);
  endfunction

  always @(posedge clk or negedge reset_n) model_step();

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_count",  32'(count_o),        32'(q.size()));
      chk("m_empty",  32'(empty_o),        32'(q.size() == 0));
      chk("m_full",   32'(full_o),         32'(q.size() == DEPTH));
      chk("m_afull",  32'(almost_full_o),  32'(q.size() >= AF_TH));
      chk("m_aempty", 32'(almost_empty_o), 32'(q.size() <= AE_TH));
      chk("m_data",   32'(pop_data_o),     (q.size() > 0) ? 32'(q[0]) : 32'd0);
      chk("m_ovf",    32'(overflow_o),     32'(m_ovf));
      chk("m_udf",    32'(underflow_o),    32'(m_udf));
    end
  end

  // Drive one cycle of requests; returns 1ns after the edge that consumed them.
  task automatic step(input bit ph, input logic [7:0] d, input bit pp, input bit clr);
    push_i = ph; push_data_i = d; pop_i = pp; err_clr_i = clr;
    @(posedge clk); #1;
    push_i = 1'b0; pop_i = 1'b0; err_clr_i = 1'b0;
  endtask

  logic [7:0] v;

  initial begin
    #2;
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_aempty", 32'(almost_empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_data", 32'(pop_data_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: fill 0x11..0x66, then drain in order
    for (int i = 1; i <= 6; i++) begin
      v = 8'(i * 17);
      step(1, v, 0, 0);
      chk("s1_count", 32'(count_o), 32'(i));
      chk("s1_aempty", 32'(almost_empty_o), 32'(i <= 1));
      chk("s1_afull", 32'(almost_full_o), 32'(i >= 5));
      chk("s1_full", 32'(full_o), 32'(i == 6));
    end
    for (int i = 1; i <= 6; i++) begin
      chk("s1_pop", 32'(pop_data_o), 32'(i * 17));
      step(0, 0, 1, 0);
    end
    chk("s1_empty", 32'(empty_o), 32'd1);

    // 2: pointer wrap
    for (int i = 0; i < 4; i++) step(1, 8'(8'hB0 + i), 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("s2_pre", 32'(pop_data_o), 32'(8'hB0 + i));
      step(0, 0, 1, 0);
    end
    for (int i = 0; i < 6; i++) step(1, 8'(8'hA0 + i), 0, 0);
    chk("s2_full", 32'(full_o), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("s2_pop", 32'(pop_data_o), 32'(8'hA0 + i));
      step(0, 0, 1, 0);
    end

    // 3: simultaneous push/pop while full
    for (int i = 1; i <= 6; i++) step(1, 8'(i), 0, 0);
    chk("s3_head", 32'(pop_data_o), 32'h01);
    step(1, 8'h77, 1, 0);
    chk("s3_count", 32'(count_o), 32'd6);
    chk("s3_ovf", 32'(overflow_o), 32'd0);
    for (int i = 2; i <= 6; i++) begin
      chk("s3_pop", 32'(pop_data_o), 32'(i));
      step(0, 0, 1, 0);
    end
    chk("s3_new", 32'(pop_data_o), 32'h77);
    step(0, 0, 1, 0);

    // 4: overflow, hold, clear
    for (int i = 1; i <= 6; i++) step(1, 8'(8'h30 + i), 0, 0);
    step(1, 8'h88, 0, 0);
    chk("s4_ovf", 32'(overflow_o), 32'(ERR_EN));
    chk("s4_count", 32'(count_o), 32'd6);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("s4_hold", 32'(overflow_o), 32'(ERR_EN));
    step(0, 0, 0, 1);
    chk("s4_clr", 32'(overflow_o), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      chk("s4_pop", 32'(pop_data_o), 32'(8'h30 + i));
      step(0, 0, 1, 0);
    end

    // 5: push+pop while empty
    step(1, 8'h99, 1, 0);
    chk("s5_udf", 32'(underflow_o), 32'(ERR_EN));
    chk("s5_count", 32'(count_o), 32'd1);
    chk("s5_data", 32'(pop_data_o), 32'h99);
    step(0, 0, 0, 1);
    chk("s5_clr", 32'(underflow_o), 32'd0);

    // 6: async reset at count 3
    step(1, 8'h5A, 0, 0);
    step(1, 8'h5B, 0, 0);
    chk("s6_count3", 32'(count_o), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_empty", 32'(empty_o), 32'd1);
    chk("s6_count", 32'(count_o), 32'd0);
    chk("s6_data", 32'(pop_data_o), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(1, 8'h42, 0, 0);
    chk("s6_push", 32'(pop_data_o), 32'h42);
    chk("s6_cnt1", 32'(count_o), 32'd1);
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
